dmem_responder: RTL and testbench

- Synthesizable data-memory responder: the target side of the core's data-memory request interface.
- Accepts one load or store per transaction over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns a response with read data and an error flag.
- Used in place of the zero-wait RAM so the core and the golden-model comparison are exercised under memory stalls.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, the default word geometry and the byte-lane merge.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int BYTES          = DATA_WIDTH_DEF / 8;

    // Merge one byte lane of a store: keep the old byte unless its enable is set.
    function automatic logic [7:0] apply_byte_en(input logic [7:0] old_b,
                                                 input logic [7:0] new_b,
                                                 input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a 1-cycle read.
// Reset never touches the array.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter     INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        merged = '0;
        for (int b = 0; b < NBYTES; b++) begin
            merged[b*8 +: 8] = apply_byte_en(mem[addr][b*8 +: 8], wdata[b*8 +: 8], be[b]);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= merged;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Target side of the core's data-memory request interface: one load/store per
// transaction, a fixed number of wait states, then a held response with data and error.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = BYTES * 8,
    parameter int WAIT_CYCLES = 0,
    parameter     INIT_FILE   = ""
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [ADDR_WIDTH-1:0]   daddr,
    input  logic [DATA_WIDTH-1:0]   ddata_w,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   ddata_r,
    output logic                    rsp_err
);

    localparam int WAIT_M1 = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES must be within 0..15");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("dmem_responder: DATA_WIDTH must be a multiple of 8");
    end

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    live_q;
    logic                    err_q;
    logic                    ld_q;
    logic                    accept, access;

    logic [ADDR_WIDTH-1:0]   addr_p0;
    logic [DATA_WIDTH-1:0]   wdata_p0;
    logic [DATA_WIDTH/8-1:0] be_p0;
    logic                    rd_p0, wr_p0;

    logic                    use_live;
    logic                    acc_rd, acc_wr, legal;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic [DATA_WIDTH/8-1:0] acc_be;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    assign req_ready = live_q && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = err_q;
    assign ddata_r   = ld_q ? ram_rdata : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT_M1);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A zero-wait access happens on the acceptance edge, before the request is latched.
    assign use_live  = (state_q == IDLE);
    assign acc_rd    = use_live ? MemRead  : rd_p0;
    assign acc_wr    = use_live ? MemWrite : wr_p0;
    assign acc_addr  = use_live ? daddr    : addr_p0;
    assign acc_wdata = use_live ? ddata_w  : wdata_p0;
    assign acc_be    = use_live ? byte_en  : be_p0;
    assign legal     = acc_rd ^ acc_wr;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            live_q  <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            if (access) begin
                err_q <= !legal;
                ld_q  <= legal && acc_rd;
            end else if (state_q == RESP && rsp_ready) begin
                err_q <= 1'b0;
                ld_q  <= 1'b0;
            end
        end
    end

    // Request capture stage: inputs are sampled only on the acceptance edge.
    always_ff @(posedge CLK) begin
        if (accept) begin
            addr_p0  <= daddr;
            wdata_p0 <= ddata_w;
            be_p0    <= byte_en;
            rd_p0    <= MemRead;
            wr_p0    <= MemWrite;
        end
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk   (CLK),
        .en    (access && legal),
        .we    (acc_wr),
        .addr  (acc_addr),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a zero-wait and a three-wait instance share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_dmem_responder;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          CLK       = 1'b0;
    logic          RESET_N   = 1'b1;
    logic          req_valid = 1'b0;
    logic          MemRead   = 1'b0;
    logic          MemWrite  = 1'b0;
    logic          rsp_ready = 1'b1;
    logic [AW-1:0] daddr     = '0;
    logic [DW-1:0] ddata_w   = '0;
    logic [3:0]    byte_en   = '0;

    logic          rq [2];
    logic          rv [2];
    logic          re [2];
    logic [DW-1:0] dr [2];

    always #5 CLK = ~CLK;

    dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0), .INIT_FILE("")) u0 (
        .CLK(CLK), .RESET_N(RESET_N), .req_valid(req_valid), .req_ready(rq[0]),
        .MemRead(MemRead), .MemWrite(MemWrite), .daddr(daddr), .ddata_w(ddata_w),
        .byte_en(byte_en), .rsp_valid(rv[0]), .rsp_ready(rsp_ready),
        .ddata_r(dr[0]), .rsp_err(re[0]));

    dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(3), .INIT_FILE("")) u3 (
        .CLK(CLK), .RESET_N(RESET_N), .req_valid(req_valid), .req_ready(rq[1]),
        .MemRead(MemRead), .MemWrite(MemWrite), .daddr(daddr), .ddata_w(ddata_w),
        .byte_en(byte_en), .rsp_valid(rv[1]), .rsp_ready(rsp_ready),
        .ddata_r(dr[1]), .rsp_err(re[1]));

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    // Transaction-level model: a request is due WAIT edges after acceptance;
    // the memory effect and the response value are computed on that edge.
    int            ecount = 0;
    bit            m_live [2];
    bit            m_pend [2];
    bit            m_resp [2];
    bit            m_err  [2];
    int            m_due  [2];
    logic [DW-1:0] m_data [2];
    bit            q_rd   [2];
    bit            q_wr   [2];
    logic [AW-1:0] q_addr [2];
    logic [DW-1:0] q_wd   [2];
    logic [3:0]    q_be   [2];
    logic [DW-1:0] mmem   [2][1024];

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 2; i++) begin
                m_live[i] = 1'b0;
                m_pend[i] = 1'b0;
                m_resp[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_resp[i]) begin
                    if (rsp_ready) begin
                        m_resp[i] = 1'b0;
                        m_pend[i] = 1'b0;
                    end
                end else if (!m_pend[i] && m_live[i] && req_valid) begin
                    q_rd[i]   = MemRead;
                    q_wr[i]   = MemWrite;
                    q_addr[i] = daddr;
                    q_wd[i]   = ddata_w;
                    q_be[i]   = byte_en;
                    m_pend[i] = 1'b1;
                    m_due[i]  = ecount + wait_of(i);
                end
                if (m_pend[i] && !m_resp[i] && ecount == m_due[i]) begin
                    m_err[i]  = 1'b0;
                    m_data[i] = '0;
                    if (q_rd[i] == q_wr[i]) begin
                        m_err[i] = 1'b1;
                    end else if (q_wr[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (q_be[i][b]) mmem[i][q_addr[i]][b*8 +: 8] = q_wd[i][b*8 +: 8];
                    end else begin
                        m_data[i] = mmem[i][q_addr[i]];
                    end
                    m_resp[i] = 1'b1;
                end
                m_live[i] = 1'b1;
            end
            ecount++;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d.req_ready", wait_of(i)), DW'(rq[i]), DW'(m_live[i] && !m_pend[i]));
                check($sformatf("u%0d.rsp_valid", wait_of(i)), DW'(rv[i]), DW'(m_resp[i]));
                check($sformatf("u%0d.rsp_err", wait_of(i)), DW'(re[i]), DW'(m_resp[i] && m_err[i]));
                check($sformatf("u%0d.ddata_r", wait_of(i)), dr[i], m_resp[i] ? m_data[i] : '0);
            end
        end
    end

    // Issue one request to both instances (called #1 after a rising edge with both idle)
    // and record, per instance, how many falling edges pass before rsp_valid shows.
    task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be,
                         output logic [DW-1:0] data0, output logic [DW-1:0] data3,
                         output bit err0, output bit err3, output int lat0, output int lat3);
        data0 = '0; data3 = '0; err0 = 1'b0; err3 = 1'b0; lat0 = 0; lat3 = 0;
        MemRead = rd; MemWrite = wr; daddr = a; ddata_w = d; byte_en = be;
        rsp_ready = 1'b1; req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 20 && (lat0 == 0 || lat3 == 0); k++) begin
            @(negedge CLK);
            if (lat0 == 0 && rv[0]) begin lat0 = k; data0 = dr[0]; err0 = re[0]; end
            if (lat3 == 0 && rv[1]) begin lat3 = k; data3 = dr[1]; err3 = re[1]; end
        end
        @(posedge CLK); #1;
    endtask

    logic [DW-1:0] d0, d3;
    bit            e0, e3;
    int            l0, l3;
    int            seen;

    initial begin
        #1 RESET_N = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset.req_ready3", DW'(rq[1]), 0);
        check("reset.ddata_r3", dr[1], 0);
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        check("release.req_ready0", DW'(rq[0]), 1);

        // full store then load, zero and three wait states
        issue(1'b0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF, d0, d3, e0, e3, l0, l3);
        check("store.lat0", l0, 1);
        check("store.lat3", l3, 4);
        check("store.err0", DW'(e0), 0);
        issue(1'b1, 1'b0, 10'd5, 32'h0, 4'h0, d0, d3, e0, e3, l0, l3);
        check("load.data0", d0, 32'hDEADBEEF);
        check("load.data3", d3, 32'hDEADBEEF);
        check("load.lat3", l3, 4);
        check("load.err3", DW'(e3), 0);

        // partial store of byte 1
        issue(1'b0, 1'b1, 10'd5, 32'h0000AA00, 4'b0010, d0, d3, e0, e3, l0, l3);
        issue(1'b1, 1'b0, 10'd5, 32'h0, 4'h0, d0, d3, e0, e3, l0, l3);
        check("partial.data0", d0, 32'hDEADAAEF);
        check("partial.data3", d3, 32'hDEADAAEF);

        // backpressure: response held, request line kept asserted, inputs disturbed
        MemRead = 1'b1; MemWrite = 1'b0; daddr = 10'd5; byte_en = 4'h0;
        rsp_ready = 1'b0; req_valid = 1'b1;
        @(posedge CLK); #1;
        MemWrite = 1'b1; daddr = 10'd9; ddata_w = 32'h55555555; byte_en = 4'hF;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge CLK);
            if (rv[1]) seen = 1;
        end
        check("bp.reached", seen, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            check("bp.valid3", DW'(rv[1]), 1);
            check("bp.data3", dr[1], 32'hDEADAAEF);
            check("bp.data0", dr[0], 32'hDEADAAEF);
            check("bp.ready0", DW'(rq[0]), 0);
        end
        @(posedge CLK); #1;
        req_valid = 1'b0; rsp_ready = 1'b1; MemWrite = 1'b0;
        @(posedge CLK); #1;

        // illegal requests: both and neither
        issue(1'b1, 1'b1, 10'd5, 32'hFFFFFFFF, 4'hF, d0, d3, e0, e3, l0, l3);
        check("illegal.err0", DW'(e0), 1);
        check("illegal.err3", DW'(e3), 1);
        check("illegal.data3", d3, 0);
        issue(1'b0, 1'b0, 10'd5, 32'hFFFFFFFF, 4'hF, d0, d3, e0, e3, l0, l3);
        check("none.err0", DW'(e0), 1);
        issue(1'b1, 1'b0, 10'd5, 32'h0, 4'h0, d0, d3, e0, e3, l0, l3);
        check("after_illegal.data3", d3, 32'hDEADAAEF);

        // reset while the three-wait instance is busy with a store
        issue(1'b0, 1'b1, 10'd7, 32'hCAFEF00D, 4'hF, d0, d3, e0, e3, l0, l3);
        MemRead = 1'b0; MemWrite = 1'b1; daddr = 10'd7; ddata_w = 32'h12345678; byte_en = 4'hF;
        rsp_ready = 1'b1; req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        #1;
        check("rst.valid3", DW'(rv[1]), 0);
        check("rst.ready3", DW'(rq[1]), 0);
        check("rst.err3", DW'(re[1]), 0);
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        @(posedge CLK); #1;
        check("rst.ready_after3", DW'(rq[1]), 1);
        issue(1'b1, 1'b0, 10'd7, 32'h0, 4'h0, d0, d3, e0, e3, l0, l3);
        check("rst.data3", d3, 32'hCAFEF00D);
        check("rst.data0", d0, 32'h12345678);

        repeat (2) @(posedge CLK);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
